input_logic: RTL and testbench

INPUT_LOGIC -- requirements
Module: input_logic

---
 rtl/proc_pkg.sv | 14 +
 rtl/debounce.sv | 27 ++
 rtl/input_logic.sv | 125 ++++++++++++
 tb/tb_input_logic.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared types and widths for the instruction input front end.
package proc_pkg;
  localparam int WORD_W   = 10;
  localparam int NUM_KEYS = 2;
  localparam int KEY_EXEC = 0;
  localparam int KEY_PEEK = 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} in_state_t;

  typedef struct packed {
    logic              vld;
    logic [WORD_W-1:0] word;
  } pend_t;
endpackage

// File: rtl/debounce.sv
// Per-key debouncer: the stable level follows the input only after it has
// differed for DB_LIMIT consecutive cycles. Reset level is released (1).
module debounce #(
  parameter int DB_LIMIT = 50000,
  parameter int DB_W     = 16
) (
  input  logic CLK,
  input  logic RESETb,
  input  logic IN,
  output logic STABLE
);
  logic [DB_W-1:0] cnt;

  always_ff @(posedge CLK or negedge RESETb) begin
    if (!RESETb) begin
      cnt    <= '0;
      STABLE <= 1'b1;
    end else if (IN == STABLE) begin
      cnt <= '0;
    end else if (cnt == DB_W'(DB_LIMIT - 1)) begin
      STABLE <= IN;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/input_logic.sv
// Switch/pushbutton front end: synchronizes, debounces and issues captured
// instructions to the processor. Define INPUT_LOGIC_PRESS_HOLD_EN to queue one
// press that arrives while an instruction is still in flight.
module input_logic
  import proc_pkg::*;
#(
  parameter int DB_LIMIT = 50000,
  parameter int DB_W     = 16
) (
  input  logic              CLK,
  input  logic              RESETb,
  input  logic [WORD_W-1:0] SW,
  input  logic              KEY_EXECb,
  input  logic              KEY_PEEKb,
  input  logic              DONE,
  output logic [WORD_W-1:0] INSTR,
  output logic              EXEC,
  output logic              BUSY,
  output logic              PEEKb
);
  logic [1:0][WORD_W-1:0]   sw_sync;
  logic [1:0][NUM_KEYS-1:0] key_sync;
  logic [NUM_KEYS-1:0]      key_raw;
  logic [NUM_KEYS-1:0]      key_stable;
  logic                     exec_d;
  logic                     press;

  in_state_t                state, state_nxt;
  logic                     load;
  logic [WORD_W-1:0]        load_word;
  logic                     pend_vld;
  logic [WORD_W-1:0]        pend_word;

  assign key_raw[KEY_EXEC] = KEY_EXECb;
  assign key_raw[KEY_PEEK] = KEY_PEEKb;

  // Two-stage synchronizers; stage [1] is the only copy used downstream.
  always_ff @(posedge CLK or negedge RESETb) begin
    if (!RESETb) begin
      sw_sync  <= '0;
      key_sync <= '1;
    end else begin
      sw_sync  <= {sw_sync[0], SW};
      key_sync <= {key_sync[0], key_raw};
    end
  end

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    debounce #(
      .DB_LIMIT (DB_LIMIT),
      .DB_W     (DB_W)
    ) u_db (
      .CLK    (CLK),
      .RESETb (RESETb),
      .IN     (key_sync[1][k]),
      .STABLE (key_stable[k])
    );
  end

  // Press is the falling edge of the debounced execute level; release is ignored.
  always_ff @(posedge CLK or negedge RESETb) begin
    if (!RESETb) exec_d <= 1'b1;
    else         exec_d <= key_stable[KEY_EXEC];
  end

  assign press = exec_d & ~key_stable[KEY_EXEC];
  assign PEEKb = key_stable[KEY_PEEK];

`ifdef INPUT_LOGIC_PRESS_HOLD_EN
  pend_t pend;

  // Any IDLE cycle with a pending press issues it, so IDLE always drains the flag.
  always_ff @(posedge CLK or negedge RESETb) begin
    if (!RESETb)             pend <= '0;
    else if (state == IDLE)  pend.vld <= 1'b0;
    else if (press)          pend <= '{vld: 1'b1, word: sw_sync[1]};
  end

  assign pend_vld  = pend.vld;
  assign pend_word = pend.word;
`else
  assign pend_vld  = 1'b0;
  assign pend_word = '0;
`endif

  always_ff @(posedge CLK or negedge RESETb) begin
    if (!RESETb) begin
      state <= IDLE;
      INSTR <= '0;
    end else begin
      state <= state_nxt;
      if (load) INSTR <= load_word;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_word = sw_sync[1];
    EXEC      = 1'b0;
    BUSY      = 1'b0;
    unique case (state)
      IDLE: begin
        if (press) begin
          load      = 1'b1;
          state_nxt = ISSUE;
        end else if (pend_vld) begin
          load      = 1'b1;
          load_word = pend_word;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        EXEC      = 1'b1;
        BUSY      = 1'b1;
        state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        BUSY = 1'b1;
        if (DONE) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_input_logic.sv
// Randomized and directed bench for input_logic against a cycle-level model.
module tb_input_logic;
  import proc_pkg::*;

  localparam int DB_LIMIT = 4;
  localparam int DB_W     = 4;
`ifdef INPUT_LOGIC_PRESS_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              RESETb = 1'b0;
  logic [WORD_W-1:0] SW = '0;
  logic              KEY_EXECb = 1'b1;
  logic              KEY_PEEKb = 1'b1;
  logic              DONE = 1'b0;
  logic [WORD_W-1:0] INSTR;
  logic              EXEC, BUSY, PEEKb;

  int n_checks = 0;
  int n_fail   = 0;
  int exec_cnt = 0;
  int busy_cnt = 0;

  input_logic #(.DB_LIMIT(DB_LIMIT), .DB_W(DB_W)) dut (
    .CLK(CLK), .RESETb(RESETb), .SW(SW), .KEY_EXECb(KEY_EXECb),
    .KEY_PEEKb(KEY_PEEKb), .DONE(DONE), .INSTR(INSTR), .EXEC(EXEC),
    .BUSY(BUSY), .PEEKb(PEEKb)
  );

  always #5 CLK = ~CLK;

  // Behavioural model: inputs seen two edges late, a key level accepted after
  // DB_LIMIT consecutive differing samples, then a busy/exec handshake.
  logic [WORD_W-1:0] m_sw0 = '0, m_sw1 = '0;
  logic              m_key0 [2] = '{1'b1, 1'b1};
  logic              m_key1 [2] = '{1'b1, 1'b1};
  logic              m_stab [2] = '{1'b1, 1'b1};
  int                m_run  [2] = '{0, 0};
  logic              m_ex_prev = 1'b1;
  logic              m_busy = 1'b0, m_exec = 1'b0, m_pend = 1'b0;
  logic [WORD_W-1:0] m_instr = '0, m_pend_word = '0;
  logic              m_press, m_start;

  always @(posedge CLK or negedge RESETb) begin
    if (!RESETb) begin
      m_sw0 = '0; m_sw1 = '0;
      for (int k = 0; k < 2; k++) begin
        m_key0[k] = 1'b1; m_key1[k] = 1'b1; m_stab[k] = 1'b1; m_run[k] = 0;
      end
      m_ex_prev = 1'b1; m_busy = 1'b0; m_exec = 1'b0; m_pend = 1'b0;
      m_instr = '0; m_pend_word = '0;
    end else begin
      m_press = m_ex_prev && !m_stab[0];
      m_start = 1'b0;
      if (!m_busy) begin
        if (m_press) begin
          m_instr = m_sw1; m_start = 1'b1;
        end else if (m_pend) begin
          m_instr = m_pend_word; m_start = 1'b1;
        end
        if (m_start) begin
          m_busy = 1'b1; m_exec = 1'b1; m_pend = 1'b0;
        end
      end else begin
        if (m_press && HOLD) begin
          m_pend = 1'b1; m_pend_word = m_sw1;
        end
        if (m_exec)    m_exec = 1'b0;
        else if (DONE) m_busy = 1'b0;
      end
      m_ex_prev = m_stab[0];
      for (int k = 0; k < 2; k++) begin
        if (m_key1[k] != m_stab[k]) begin
          m_run[k]++;
          if (m_run[k] == DB_LIMIT) begin
            m_stab[k] = m_key1[k]; m_run[k] = 0;
          end
        end else begin
          m_run[k] = 0;
        end
      end
      m_sw1 = m_sw0; m_sw0 = SW;
      m_key1[0] = m_key0[0]; m_key1[1] = m_key0[1];
      m_key0[0] = KEY_EXECb; m_key0[1] = KEY_PEEKb;
    end
  end

  always @(negedge CLK) begin
    n_checks++;
    if ({INSTR, EXEC, BUSY, PEEKb} !== {m_instr, m_exec, m_busy, m_stab[1]}) begin
      n_fail++;
      $display("FAIL cycle_compare t=%0t: got INSTR=%h EXEC=%b BUSY=%b PEEKb=%b, expected INSTR=%h EXEC=%b BUSY=%b PEEKb=%b",
               $time, INSTR, EXEC, BUSY, PEEKb, m_instr, m_exec, m_busy, m_stab[1]);
    end
    if (EXEC === 1'b1) exec_cnt++;
    if (BUSY === 1'b1) busy_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  // Returns the index of the first edge after which EXEC is high, or -1.
  task automatic wait_exec(output int lat, input int maxc);
    lat = -1;
    for (int k = 0; k <= maxc; k++) begin
      @(posedge CLK);
      #1;
      if (EXEC === 1'b1) begin
        lat = k;
        break;
      end
    end
    #1;
  endtask

  initial begin
    int lat, e0, b0;
    logic [WORD_W-1:0] i0;

    #23;
    check("rst_instr", INSTR, 0);
    check("rst_exec", EXEC, 0);
    check("rst_busy", BUSY, 0);
    check("rst_peek", PEEKb, 1);
    @(posedge CLK); #2;
    RESETb = 1'b1;
    step(3);

    // Clean press: latency, captured word, busy until DONE
    SW = 10'h2A5; step(3);
    KEY_EXECb = 1'b0;
    wait_exec(lat, 20);
    check("exec_latency", lat, 6);
    check("instr_2a5", INSTR, 10'h2A5);
    check("model_instr_2a5", m_instr, 10'h2A5);
    step(3);
    check("busy_wait_done", BUSY, 1);
    DONE = 1'b1; step(1); DONE = 1'b0;
    check("busy_after_done", BUSY, 0);
    KEY_EXECb = 1'b1; step(8);

    // Bouncing key never settles long enough
    e0 = exec_cnt;
    for (int i = 0; i < 10; i++) begin
      KEY_EXECb = ~KEY_EXECb;
      step(2);
    end
    step(10);
    check("bounce_no_exec", exec_cnt - e0, 0);
    check("bounce_idle", BUSY, 0);

    // Peek is a plain debounced level
    i0 = INSTR; e0 = exec_cnt;
    KEY_PEEKb = 1'b0; step(10);
    check("peek_low", PEEKb, 0);
    check("peek_instr_held", INSTR, i0);
    check("peek_no_exec", exec_cnt - e0, 0);
    check("peek_not_busy", BUSY, 0);
    KEY_PEEKb = 1'b1; step(8);
    check("peek_release", PEEKb, 1);

    // Second press while waiting for DONE
    SW = 10'h2A5; step(3);
    KEY_EXECb = 1'b0;
    wait_exec(lat, 20);
    check("first_press_seen", lat, 6);
    KEY_EXECb = 1'b1; step(8);
    SW = 10'h011; step(3);
    e0 = exec_cnt;
    KEY_EXECb = 1'b0; step(10);
    KEY_EXECb = 1'b1; step(8);
    check("busy_before_done2", BUSY, 1);
    check("instr_held_busy", INSTR, 10'h2A5);
    DONE = 1'b1; step(1); DONE = 1'b0;
    step(6);
    check("held_press_exec", exec_cnt - e0, HOLD ? 1 : 0);
    check("held_press_instr", INSTR, HOLD ? 10'h011 : 10'h2A5);
    check("held_press_busy", BUSY, HOLD ? 1 : 0);
    DONE = 1'b1; step(1); DONE = 1'b0; step(3);

    // Reset in WAIT_DONE abandons the instruction
    SW = 10'h155; step(3);
    KEY_EXECb = 1'b0;
    wait_exec(lat, 20);
    KEY_EXECb = 1'b1; SW = 10'h3FF; step(8);
    check("busy_pre_rst", BUSY, 1);
    RESETb = 1'b0; #1;
    check("arst_instr", INSTR, 0);
    check("arst_exec", EXEC, 0);
    check("arst_busy", BUSY, 0);
    check("arst_peek", PEEKb, 1);
    step(2);
    RESETb = 1'b1;
    e0 = exec_cnt;
    step(20);
    check("no_exec_after_rst", exec_cnt - e0, 0);
    check("idle_after_rst", BUSY, 0);

    // Key held across reset registers as a press afterwards
    KEY_EXECb = 1'b0;
    RESETb = 1'b0; step(2); RESETb = 1'b1;
    wait_exec(lat, 20);
    check("held_through_reset", lat, 6);
    check("held_through_reset_instr", INSTR, 10'h3FF);
    KEY_EXECb = 1'b1;
    DONE = 1'b1; step(2); DONE = 1'b0; step(8);

    // DONE already high through ISSUE
    DONE = 1'b1; step(2);
    b0 = busy_cnt; e0 = exec_cnt;
    KEY_EXECb = 1'b0; step(20);
    check("done_high_busy_cycles", busy_cnt - b0, 2);
    check("done_high_exec", exec_cnt - e0, 1);
    check("done_high_idle", BUSY, 0);
    KEY_EXECb = 1'b1; DONE = 1'b0; step(8);

    // Random traffic, checked every cycle by the compare process
    for (int i = 0; i < 400; i++) begin
      case (int'($urandom_range(0, 9)))
        0, 1, 2: KEY_EXECb = ~KEY_EXECb;
        3:       KEY_PEEKb = ~KEY_PEEKb;
        4, 5:    SW = WORD_W'($urandom);
        6, 7:    DONE = ~DONE;
        8: begin
          RESETb = 1'b0; step(1); RESETb = 1'b1;
        end
        default: ;
      endcase
      step(int'($urandom_range(1, 8)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
